// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and line-level constants
//
// Contents:
//   tx_state_t   transmitter FSM states (IDLE, START, DATA, PARITY, STOP)
//   UART_IDLE    line level while idle and during stop bits (mark)
//   UART_START   line level of the start bit (space)
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic UART_IDLE  = 1'b1;
    localparam logic UART_START = 1'b0;

endpackage

// File: rtl/uart_tx_baud_tick_detect.sv
// rtl/uart_tx_baud_tick_detect.sv - rising-edge detector turning the baud square wave into a bit enable
//
// Ports:
//   clk_100MHz  in   system clock
//   rst         in   asynchronous active-high reset
//   s_clk       in   baud square wave, synchronous to clk_100MHz
//   tick        out  one-cycle pulse on each rising edge of s_clk
module baud_tick_detect (
    input  logic clk_100MHz,
    input  logic rst,
    input  logic s_clk,
    output logic tick
);

    logic s_clk_d;

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            s_clk_d <= 1'b0;
        end else begin
            s_clk_d <= s_clk;
        end
    end

    // s_clk is only ever sampled as data; its rising edge becomes an enable.
    assign tick = s_clk & ~s_clk_d;

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, LSB-first data, optional parity, 1 or 2 stop bits
//
// Parameters:
//   DATA_BITS   data bits per frame (5..8)
//   PARITY_EN   1 inserts a parity bit after the data bits
//   PARITY_ODD  0 even parity, 1 odd parity
//   STOP_BITS   number of stop bits (1 or 2)
// Ports:
//   clk_100MHz  in   system clock
//   rst         in   asynchronous active-high reset
//   s_clk       in   baud square wave; each rising edge advances one bit
//   tx_start    in   send request, accepted only while idle
//   tx_data     in   frame payload, sampled on acceptance
//   tx          out  serial line, idle high
//   tx_busy     out  high from the cycle after acceptance until frame end
//   tx_done     out  one-cycle pulse at frame end
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk_100MHz,
    input  logic                 rst,
    input  logic                 s_clk,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);

    tx_state_t            state;
    logic [DATA_BITS-1:0] shift;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 stop_cnt;
    logic                 parity;
    logic                 wait_tick;
    logic                 tick;

    baud_tick_detect u_tick (
        .clk_100MHz(clk_100MHz),
        .rst       (rst),
        .s_clk     (s_clk),
        .tick      (tick)
    );

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift     <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            parity    <= 1'b0;
            wait_tick <= 1'b0;
            tx        <= UART_IDLE;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx      <= UART_IDLE;
                    tx_busy <= 1'b0;
                    // A tick in the acceptance cycle is ignored: the start
                    // bit waits for the next tick so it is a full period.
                    if (tx_start) begin
                        shift     <= tx_data;
                        parity    <= (^tx_data) ^ (PARITY_ODD != 0);
                        wait_tick <= 1'b1;
                        tx_busy   <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (wait_tick) begin
                            tx        <= UART_START;
                            bit_cnt   <= '0;
                            wait_tick <= 1'b0;
                        end else begin
                            tx    <= shift[0];
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift   <= shift >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
                            if (PARITY_EN != 0) begin
                                tx    <= parity;
                                state <= PARITY;
                            end else begin
                                tx       <= UART_IDLE;
                                stop_cnt <= 1'b0;
                                state    <= STOP;
                            end
                        end else begin
                            // Registered output: present the next bit now so
                            // it appears on the line right after this tick.
                            tx <= shift[1];
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        tx       <= UART_IDLE;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (stop_cnt == 1'(STOP_BITS - 1)) begin
                            tx_done <= 1'b1;
                            tx_busy <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx    <= UART_IDLE;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx over 8N1, 8E1, 8O2 and 5O1 configurations
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_clk = 1'b0;
    logic       btick = 1'b0;
    logic [1:0] bcnt = 2'd0;
    logic       start;
    logic [1:0] sel;
    logic [7:0] data;
    logic [3:0] start_v;
    logic [3:0] tx_v;
    logic [3:0] busy_v;
    logic [3:0] done_v;

    int total = 0;
    int bad   = 0;

    // Per-instance frame format: data bits, parity enable, odd parity, stop bits
    int db [4] = '{8, 8, 8, 5};
    int pe [4] = '{0, 1, 1, 1};
    int po [4] = '{0, 0, 1, 1};
    int sb [4] = '{1, 1, 2, 1};

    always #5 clk = ~clk;

    // Baud generator with BAUD_DIV=4; btick marks the cycle in which s_clk has just risen.
    always @(posedge clk) begin
        bcnt <= bcnt + 2'd1;
        if (bcnt == 2'd3) begin
            s_clk <= ~s_clk;
            btick <= ~s_clk;
        end else begin
            btick <= 1'b0;
        end
    end

    assign start_v = start ? (4'b0001 << sel) : 4'b0000;

    uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
        .clk_100MHz(clk), .rst(rst), .s_clk(s_clk), .tx_start(start_v[0]), .tx_data(data),
        .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));
    uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
        .clk_100MHz(clk), .rst(rst), .s_clk(s_clk), .tx_start(start_v[1]), .tx_data(data),
        .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));
    uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_8o2 (
        .clk_100MHz(clk), .rst(rst), .s_clk(s_clk), .tx_start(start_v[2]), .tx_data(data),
        .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));
    uart_tx #(.DATA_BITS(5), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_5o1 (
        .clk_100MHz(clk), .rst(rst), .s_clk(s_clk), .tx_start(start_v[3]), .tx_data(data[4:0]),
        .tx(tx_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]));

    function automatic int frame_len(input int s);
        return 1 + db[s] + pe[s] + sb[s];
    endfunction

    // Entered at the negedge of the acceptance cycle with start/data already driven.
    // Checks the whole frame cycle by cycle against the line sequence built from the
    // frame rules. ign_at >= 0 pulses a second request (0x3C) at that frame cycle.
    // chain=1 issues the next request (nd) in the tx_done cycle.
    task automatic do_frame(input int s, input logic [7:0] d, input int ign_at,
                            input bit chain, input logic [7:0] nd);
        logic [15:0] expv;
        logic        par;
        int          len;
        bit          found;
        len     = frame_len(s);
        expv    = '1;
        expv[0] = 1'b0;
        par     = (po[s] != 0);
        for (int i = 0; i < db[s]; i++) begin
            expv[1 + i] = d[i];
            par         = par ^ d[i];
        end
        if (pe[s] != 0) expv[1 + db[s]] = par;

        @(negedge clk);
        start = 1'b0;
        data  = 8'($urandom);
        found = 1'b0;
        for (int w = 0; w < 10; w++) begin
            total++;
            if (tx_v[s] !== 1'b1 || busy_v[s] !== 1'b1 || done_v[s] !== 1'b0) begin
                bad++;
                $display("FAIL pre_start inst=%0d tx/busy/done=%b%b%b required 110",
                         s, tx_v[s], busy_v[s], done_v[s]);
            end
            if (btick) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL tick_timeout inst=%0d no baud tick within 10 cycles", s);
            return;
        end

        for (int c = 0; c < len * 8; c++) begin
            @(negedge clk);
            total++;
            if ({tx_v[s], busy_v[s], done_v[s]} !== {expv[c / 8], 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL frame_bit inst=%0d data=%h cycle=%0d tx/busy/done=%b%b%b required %b10",
                         s, d, c, tx_v[s], busy_v[s], done_v[s], expv[c / 8]);
            end
            if (c == ign_at) begin
                start = 1'b1;
                data  = 8'h3C;
            end else if (c == ign_at + 1) begin
                start = 1'b0;
            end
        end

        @(negedge clk);
        total++;
        if ({tx_v[s], busy_v[s], done_v[s]} !== 3'b101) begin
            bad++;
            $display("FAIL frame_end inst=%0d data=%h tx/busy/done=%b%b%b required 101",
                     s, d, tx_v[s], busy_v[s], done_v[s]);
        end
        if (chain) begin
            start = 1'b1;
            data  = nd;
        end else begin
            repeat (12) begin
                @(negedge clk);
                total++;
                if ({tx_v[s], busy_v[s], done_v[s]} !== 3'b100) begin
                    bad++;
                    $display("FAIL post_idle inst=%0d tx/busy/done=%b%b%b required 100",
                             s, tx_v[s], busy_v[s], done_v[s]);
                end
            end
        end
    endtask

    task automatic begin_req(input int s, input logic [7:0] d);
        @(negedge clk);
        sel   = 2'(s);
        data  = d;
        start = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (tx_v !== 4'hF || busy_v !== 4'h0 || done_v !== 4'h0) begin
                bad++;
                $display("FAIL reset_hold tx=%b busy=%b done=%b required 1111/0000/0000", tx_v, busy_v, done_v);
            end
        end
        rst = 1'b0;
        repeat (50) begin
            @(negedge clk);
            total++;
            if (tx_v !== 4'hF || busy_v !== 4'h0 || done_v !== 4'h0) begin
                bad++;
                $display("FAIL reset_idle tx=%b busy=%b done=%b required 1111/0000/0000", tx_v, busy_v, done_v);
            end
        end
    endtask

    task automatic test_8n1();
        begin_req(0, 8'hA5);
        do_frame(0, 8'hA5, -1, 1'b0, 8'h00);
    endtask

    task automatic test_parity();
        begin_req(1, 8'h07);
        do_frame(1, 8'h07, -1, 1'b0, 8'h00);
        begin_req(2, 8'h07);
        do_frame(2, 8'h07, -1, 1'b0, 8'h00);
    endtask

    task automatic test_ignored();
        begin_req(0, 8'h11);
        do_frame(0, 8'h11, 30, 1'b0, 8'h00);
    endtask

    task automatic test_back_to_back();
        begin_req(0, 8'hC3);
        do_frame(0, 8'hC3, -1, 1'b1, 8'h55);
        do_frame(0, 8'h55, -1, 1'b0, 8'h00);
    endtask

    task automatic test_mid_reset();
        bit found;
        begin_req(0, 8'h00);
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int w = 0; w < 10; w++) begin
            if (btick) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL mid_reset_tick no baud tick within 10 cycles");
        end
        // Start bit occupies cycles 0..7, data bit 3 occupies 32..39.
        repeat (36) @(negedge clk);
        total++;
        if (tx_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_pre tx/busy=%b%b required 01", tx_v[0], busy_v[0]);
        end
        rst = 1'b1;
        #1;
        total++;
        if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_async tx/busy/done=%b%b%b required 100", tx_v[0], busy_v[0], done_v[0]);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) begin
            @(negedge clk);
            total++;
            if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset_after tx/busy/done=%b%b%b required 100", tx_v[0], busy_v[0], done_v[0]);
            end
        end
        begin_req(0, 8'h96);
        do_frame(0, 8'h96, -1, 1'b0, 8'h00);
    endtask

    task automatic test_random();
        int         s;
        int         ign;
        bit         ch;
        bit         pending;
        logic [7:0] d;
        logic [7:0] nd;
        pending = 1'b0;
        s       = 0;
        d       = 8'h00;
        for (int i = 0; i < 14; i++) begin
            if (!pending) begin
                s = int'($urandom_range(0, 3));
                d = 8'($urandom);
                begin_req(s, d);
            end
            ign = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, frame_len(s) * 8 - 2)) : -1;
            ch  = (i != 13) && ($urandom_range(0, 1) == 1);
            nd  = 8'($urandom);
            do_frame(s, d, ign, ch, nd);
            pending = ch;
            d       = nd;
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        sel   = 2'd0;
        data  = 8'h00;
        test_reset();
        test_8n1();
        test_parity();
        test_ignored();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter that consumes the baud-rate square wave `s_clk` from the baud generator and shifts a parallel byte out on `tx`, LSB first, framed as start, data, optional parity, and stop bits. It sits directly downstream of the baud generator in the UART datapath and is clocked by the same `clk_100MHz`. `s_clk` is never used as a clock. Its rising edges are detected inside this block and used as a one-cycle bit-enable.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal range 5–8.
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0.
- `STOP_BITS`, default 1: number of stop bits; legal values 1 or 2.
- `clk_100MHz` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `s_clk` in 1: baud square wave from the baud generator, synchronous to `clk_100MHz`.
- `tx_start` in 1: request to send, single-cycle or held.
- `tx_data` in `DATA_BITS`: byte to send, sampled when a request is accepted.
- `tx` out 1: serial line, idle high.
- `tx_busy` out 1: high from the cycle after acceptance until the frame ends.
- `tx_done` out 1: one-cycle pulse at the end of the frame.

## Operation
- Bit tick:
  - `s_clk_d` is `s_clk` registered once.
  - `tick = s_clk & ~s_clk_d`, which pulses once per `s_clk` period (2×`BAUD_DIV` clocks).
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `tx`=1 and `tx_busy`=0.
  - When `tx_start`=1, latch `tx_data` into the shift register, compute parity from the latched data, and go to WAIT_TICK. WAIT_TICK is a sub-condition of START, not a separate state.
- START:
  - `tx` stays 1 until the first tick after acceptance.
  - On that tick, `tx`=0 and the bit counter is cleared.
  - On the next tick, go to DATA.
- DATA:
  - `tx` = `shift[0]`.
  - On each tick, shift right and increment the bit counter.
  - After `DATA_BITS` ticks, go to PARITY if `PARITY_EN`=1, otherwise STOP.
- PARITY:
  - `tx` = (XOR of the data) XOR `PARITY_ODD`.
  - Go to STOP on the next tick.
- STOP:
  - `tx`=1 for `STOP_BITS` tick intervals.
  - On the final tick, go to IDLE with `tx_done`=1 for one cycle.
- Bit-counter width: `$clog2(DATA_BITS+1)`. The counter never wraps within a frame.
- `tx_start` while `tx_busy`=1 is ignored. No queuing, and `tx_data` is not re-sampled.
- `tx_data` changes after acceptance do not affect the frame in flight.

## Timing
- Reset values: `tx`=1, `tx_busy`=0, `tx_done`=0, state IDLE, `s_clk_d`=0, shift register and counters 0.
- Acceptance and busy:
  - `tx_start` is accepted in cycle N.
  - `tx_busy`=1 from N+1.
  - A tick coincident with cycle N is not counted.
- Start bit: `tx` falls in the cycle after the first tick strictly after N.
- Each bit is held for exactly one tick period. All outputs are registered, so each `tx` transition lags its tick by one cycle.
- Frame length is 1+`DATA_BITS`+`PARITY_EN`+`STOP_BITS` tick periods from the start-bit edge.
- Frame end:
  - `tx_done` and the falling `tx_busy` occur in the same cycle, one cycle after the final stop tick.
  - A `tx_start` in that cycle is accepted, giving back-to-back frames with no extra idle bit beyond the stop bits.
- Reset mid-frame forces `tx`=1 immediately and abandons the frame. No `tx_done` is produced.
- `s_clk` stuck at 0 or 1: no ticks occur and the FSM holds its current state indefinitely.

## Structure
- Package `uart_pkg` holds:
  - the `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP);
  - the line-level constants `UART_IDLE`=1 and `UART_START`=0.
- Sub-module `baud_tick_detect` takes `clk_100MHz`, `rst`, and `s_clk`, and produces `tick`. The future `uart_rx` reuses it.

## Test plan
All scenarios use a baud generator with `BAUD_DIV`=4, so a tick occurs every 8 clocks.
- **Reset:**
  - Stimulus: assert `rst` for 3 cycles, then release and idle for 50 cycles.
  - Required: `tx`=1, `tx_busy`=0, `tx_done`=0 throughout.
- **8N1 frame:**
  - Stimulus: `tx_data`=0xA5 with a 1-cycle `tx_start`.
  - Required: line reads 0, 1,0,1,0,0,1,0,1, then 1, each held 8 cycles; exactly one `tx_done` pulse; `tx_busy` high for the whole frame.
- **8E1 and 8O2:**
  - Stimulus: `PARITY_EN`=1; send 0x07 with `PARITY_ODD`=0, then again with `PARITY_ODD`=1 and `STOP_BITS`=2.
  - Required: parity bit is 1 for even, 0 for odd; stop time is 8 and 16 cycles respectively.
- **Ignored request:**
  - Stimulus: pulse `tx_start` with 0x3C mid-frame while sending 0x11.
  - Required: only 0x11 is transmitted; one `tx_done`.
- **Back-to-back:**
  - Stimulus: assert `tx_start` with 0x55 in the `tx_done` cycle of the previous frame.
  - Required: the next start bit begins at the first tick after acceptance; no gap beyond the stop bit.
- **Mid-frame reset:**
  - Stimulus: assert `rst` during data bit 3 of a 0x00 frame.
  - Required: `tx`=1 in the same cycle; no `tx_done`; a fresh frame afterwards is correct.
